// File: rtl/bkg_ram_loader_pkg.sv
// Shared definitions for the background frame write and read paths.
package bkg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CODE,
        GET_RUN,
        WRITE,
        DONE
    } loader_state_t;

    localparam int unsigned BKG_ADDR_W  = 20;
    localparam int unsigned BKG_COORD_W = 10;
    localparam int unsigned PLT_CODE_W  = 6;
    localparam int unsigned PLT_ENTRIES = 40;

endpackage

// File: rtl/bkg_ram_loader_if.sv
// Byte stream input and background RAM write port of the loader.
interface bkg_ram_loader_if #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] din;

    modport master (input s_data, s_valid, output s_ready, we, addr_w, din);
    modport slave  (output s_data, s_valid, input s_ready, we, addr_w, din);
endinterface

// File: rtl/bkg_ram_loader_raster_cnt.sv
// Raster-order x/y pixel counter, shared with the display side.
module raster_cnt #(
    parameter int unsigned H_PIX = 640,
    parameter int unsigned V_PIX = 480
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr_i,
    input  logic                            en_i,
    output logic [bkg_pkg::BKG_COORD_W-1:0] x_o,
    output logic [bkg_pkg::BKG_COORD_W-1:0] y_o,
    output logic                            last_pixel_o
);
    import bkg_pkg::*;

    localparam logic [BKG_COORD_W-1:0] X_LAST = BKG_COORD_W'(H_PIX - 1);
    localparam logic [BKG_COORD_W-1:0] Y_LAST = BKG_COORD_W'(V_PIX - 1);

    logic [BKG_COORD_W-1:0] x_q;
    logic [BKG_COORD_W-1:0] y_q;

    // Step through the frame one pixel per enabled cycle, wrapping at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clr_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x_o          = x_q;
    assign y_o          = y_q;
    assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);
endmodule

// File: rtl/bkg_ram_loader.sv
// Decodes a run-length byte stream of palette codes into background RAM writes.
module bkg_ram_loader #(
    parameter int unsigned H_PIX       = 640,
    parameter int unsigned V_PIX       = 480,
    parameter int unsigned ADDR_WIDTH  = bkg_pkg::BKG_ADDR_W,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PLT_ENTRIES = bkg_pkg::PLT_ENTRIES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    bkg_ram_loader_if.master         bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    import bkg_pkg::*;

    loader_state_t                   state_q;
    logic [PLT_CODE_W-1:0]           code_q;
    logic [8:0]                      run_q;
    logic                            last_q;
    logic                            we_q;
    logic [ADDR_WIDTH-1:0]           addr_q;
    logic [DATA_WIDTH-1:0]           din_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            err_q;

    logic [BKG_COORD_W-1:0]          x;
    logic [BKG_COORD_W-1:0]          y;
    logic                            last_pixel;
    logic                            xfer;
    logic                            adv;
    logic                            clr;
    logic [8:0]                      run_len;

    assign xfer    = bus.s_valid && bus.s_ready;
    assign run_len = (bus.s_data == 8'd0) ? 9'd256 : {1'b0, bus.s_data};
    assign clr     = (state_q == IDLE) && start;
    // The counter moves on every edge that registers a pixel write.
    assign adv     = ((state_q == GET_RUN) && bus.s_valid) ||
                     ((state_q == WRITE) && !last_q && (run_q != 9'd1));

    raster_cnt #(
        .H_PIX (H_PIX),
        .V_PIX (V_PIX)
    ) u_raster (
        .clk          (clk),
        .rst          (reset),
        .clr_i        (clr),
        .en_i         (adv),
        .x_o          (x),
        .y_o          (y),
        .last_pixel_o (last_pixel)
    );

    // Loader FSM: the write for a pixel is registered on the edge that moves
    // past it, so we=1 appears the cycle after the run byte is taken and
    // last_q marks the final pixel while it is on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            run_q   <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= GET_CODE;
                    end
                end
                GET_CODE: begin
                    if (xfer) begin
                        code_q <= bus.s_data[PLT_CODE_W-1:0];
                        if ({26'd0, bus.s_data[PLT_CODE_W-1:0]} >= PLT_ENTRIES)
                            err_q <= 1'b1;
                        state_q <= GET_RUN;
                    end
                end
                GET_RUN: begin
                    if (xfer) begin
                        run_q   <= run_len;
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_WIDTH'({y, x});
                        din_q   <= DATA_WIDTH'(code_q);
                        last_q  <= last_pixel;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_q) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (run_q == 9'd1) begin
                        we_q    <= 1'b0;
                        state_q <= GET_CODE;
                    end else begin
                        run_q  <= run_q - 9'd1;
                        we_q   <= 1'b1;
                        addr_q <= ADDR_WIDTH'({y, x});
                        last_q <= last_pixel;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = (state_q == GET_CODE) || (state_q == GET_RUN);
    assign bus.we      = we_q;
    assign bus.addr_w  = addr_q;
    assign bus.din     = din_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_bkg_ram_loader.sv
// Self-checking bench for bkg_ram_loader on a 4x2 frame.
module tb_bkg_ram_loader;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic err;

    int vectors     = 0;
    int miscompares = 0;

    logic [19:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    int          exp_used;
    int          exp_done;
    logic        exp_err;

    bkg_ram_loader_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) bus ();

    bkg_ram_loader #(
        .H_PIX       (H),
        .V_PIX       (V),
        .ADDR_WIDTH  (20),
        .DATA_WIDTH  (8),
        .PLT_ENTRIES (40)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk records over a flat pixel index until the frame is full.
    function automatic void model(input logic [7:0] b[$]);
        int p;
        int i;
        int cyc;
        int r;
        logic [7:0] code;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        p = 0;
        i = 0;
        cyc = 0;
        while (p < NPIX && i + 1 < b.size()) begin
            code = {2'b00, b[i][5:0]};
            r = (b[i+1] == 8'd0) ? 256 : int'(b[i+1]);
            if (code >= 8'd40) exp_err = 1'b1;
            i += 2;
            cyc += 2;
            for (int k = 0; k < r && p < NPIX; k++) begin
                exp_addr.push_back(20'(((p / H) << 10) | (p % H)));
                exp_data.push_back(code);
                p++;
                cyc++;
            end
        end
        exp_used = i;
        exp_done = cyc + 1;
    endfunction

    task automatic run_frame(input logic [7:0] b[$], input int gap_pct, input int mid_start,
                             input bit chk_timing, input string tag);
        logic [19:0] got_a[$];
        logic [7:0]  got_d[$];
        logic [7:0]  src[$];
        int cyc;
        int done_cyc;
        int last_we;
        bit seen;
        src = b;
        model(b);
        bus.s_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_ready_rise"}, 32'(bus.s_ready), 32'd1);
        check({tag, "_err_clr"}, 32'(err), 32'd0);
        seen = 1'b0;
        last_we = -1;
        done_cyc = -1;
        while (!seen && cyc < 3000) begin
            if (bus.we) begin
                got_a.push_back(bus.addr_w);
                got_d.push_back(bus.din);
                last_we = cyc;
            end
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                start = (cyc == mid_start);
                bus.s_valid = (src.size() > 0) && ($urandom_range(99) >= 32'(gap_pct));
                bus.s_data = bus.s_valid ? src[0] : 8'($urandom);
                if (bus.s_valid && bus.s_ready) void'(src.pop_front());
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_after_we"}, 32'(last_we), 32'(done_cyc - 1));
        check({tag, "_we_in_done"}, 32'(bus.we), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        if (chk_timing) check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        bus.s_valid = (src.size() > 0);
        if (src.size() > 0) bus.s_data = src[0];
        @(posedge clk); #1;
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        repeat (3) begin
            if (bus.s_valid && bus.s_ready) void'(src.pop_front());
            @(posedge clk); #1;
        end
        check({tag, "_ready_idle"}, 32'(bus.s_ready), 32'd0);
        check({tag, "_leftover"}, 32'(src.size()), 32'(b.size() - exp_used));
        bus.s_valid = 1'b0;
        check({tag, "_wr_count"}, 32'(got_a.size()), 32'(exp_addr.size()));
        for (int i = 0; i < got_a.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_a[i]), 32'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp_data[i]));
        end
    endtask

    initial begin
        logic [7:0] b[$];
        bit any_done;
        int total;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;

        // Reset state
        #12;
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_addr", 32'(bus.addr_w), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two records filling the frame exactly
        b = '{8'd5, 8'd3, 8'd7, 8'd5};
        run_frame(b, 0, -1, 1'b1, "basic");

        // Run of 256 truncated at frame end; trailing byte stays in the source
        b = '{8'h01, 8'h00, 8'h55};
        run_frame(b, 0, -1, 1'b1, "trunc");

        // Out-of-range code, with a start pulse during the write phase
        b = '{8'hE8, 8'd3, 8'h02, 8'd5};
        run_frame(b, 0, 4, 1'b1, "badcode");
        b = '{8'd9, 8'd8};
        run_frame(b, 0, -1, 1'b1, "errclr");

        // Random records, gap-free then with random s_valid gaps
        for (int t = 0; t < 4; t++) begin
            b.delete();
            total = 0;
            while (total < NPIX + 3) begin
                b.push_back(8'($urandom));
                b.push_back(($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(4, 1)));
                total += (b[b.size()-1] == 8'd0) ? 256 : int'(b[b.size()-1]);
            end
            run_frame(b, 0, -1, 1'b1, $sformatf("rnd%0d", t));
            run_frame(b, 60, 5 + t, 1'b0, $sformatf("gap%0d", t));
        end

        // Reset during a long run aborts at once
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd3;
        @(posedge clk); #1;
        bus.s_data  = 8'd100;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        check("abort_we_before", 32'(bus.we), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_addr_before", 32'(bus.addr_w), 32'h2);
        #2 reset = 1'b1;
        #1;
        check("abort_we", 32'(bus.we), 32'd0);
        check("abort_addr", 32'(bus.addr_w), 32'd0);
        check("abort_din", 32'(bus.din), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        any_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || bus.we) any_done = 1'b1;
        end
        check("abort_quiet", 32'(any_done), 32'd0);
        b = '{8'd9, 8'd8};
        run_frame(b, 0, -1, 1'b1, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
